sblock_cfg_loader: RTL and testbench
====================================

Name: sblock_cfg_loader

Overview:
- Configuration front-end that sits directly upstream of the switch-block array.
- Accepts a serial configuration bitstream, frames it into addressed 18-bit dot-control words, and checks parity.
- Each good word is driven onto a shared `bits` bus together with a one-hot, single-cycle write enable to exactly one switch block.
- Bad frames are dropped and flagged; they never produce a write.

Parameters:
- NUM_BLOCKS, 6, number of switch blocks served; width of the `wr_en_o` vector.
- ADDR_W, 3, address field width; must satisfy 2^ADDR_W >= NUM_BLOCKS.
- WORD_W, 18, payload width: 9 dots × 2 bits, as `{H[8:0], V[8:0]}`.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_bit  input  1  serial data bit, MSB first.
- cfg_sof  input  1  start-of-frame marker, qualified with cfg_valid.
- cfg_valid  input  1  cfg_bit/cfg_sof are valid this cycle.
- cfg_ready  output  1  loader can accept a bit this cycle.
- bits_o  output  WORD_W  registered payload to the Sblock `bits` inputs; `[17:9]`=H, `[8:0]`=V.
- wr_en_o  output  NUM_BLOCKS  one-hot write-enable pulse, one bit per Sblock.
- err_o  output  1  one-cycle pulse on a rejected frame.
- wr_count_o  output  8  number of successful writes since reset, saturating.

Behaviour:
- Accept rule: a bit is accepted on a rising edge where cfg_valid && cfg_ready. No other cycle has any effect on the datapath.
- Frame format: ADDR_W address bits, then WORD_W data bits, then 1 even-parity bit. All fields MSB first. The XOR of every frame bit including the parity bit must be 0.
- FSM states: IDLE, ADDR, DATA, PAR, WRITE. cfg_ready = 1 in every state except WRITE.
- IDLE:
  - Accepted bit with cfg_sof=1 is address bit 0; set bit counter=1 and go to ADDR. If ADDR_W=1, go straight to DATA.
  - Accepted bits with cfg_sof=0 are discarded silently; no err_o.
- ADDR / DATA: shift accepted bits in and increment the counter. Advance to DATA after ADDR_W address bits, and to PAR after WORD_W data bits.
- PAR: on the accepted parity bit, evaluate the frame:
  - If parity is good and address < NUM_BLOCKS, load bits_o with the data field and go to WRITE.
  - Otherwise pulse err_o in the next cycle, return to IDLE, and leave bits_o unchanged.
- WRITE: lasts exactly one cycle.
  - wr_en_o[addr]=1 and all other bits 0; bits_o already holds the new word.
  - wr_count_o increments, saturating at 255.
  - Next state is IDLE.
- Latency: wr_en_o asserts in the cycle immediately after the edge that accepted the parity bit. bits_o is stable from that cycle until the next WRITE, so an Sblock samples it on the following edge.
- Mid-frame cfg_sof=1 (any accepted bit in ADDR/DATA/PAR carrying sof):
  - Abort the current frame and pulse err_o.
  - Treat this bit as address bit 0 of a new frame and stay in or enter ADDR.
  - The err_o pulse and the restart happen together.
- WRITE ignores its inputs: cfg_ready=0 there, so no bit is accepted and cfg_sof/cfg_valid are ignored.
- wr_en_o never has more than one bit set, and is never high outside WRITE.
- err_o and wr_en_o are never high in the same cycle.
- Gaps (cfg_valid=0) anywhere in a frame are legal; the FSM holds state and the counter unchanged.
- Reset values (rst=1, asynchronous, any state, including mid-frame):
  - State = IDLE; partial frame is discarded.
  - bits_o=0, wr_en_o=0, err_o=0, wr_count_o=0, cfg_ready=1 once rst deasserts.
  - No write pulse is ever generated by reset entry or exit.

Test Plan:
- Good frame, cfg_valid held high: addr=3'b010, data=18'h2A5C3, parity=0 (22 bits, sof on the first) -> the cycle after the parity edge: wr_en_o=6'b000100 for exactly 1 cycle, bits_o=18'h2A5C3, err_o=0, wr_count_o=1, cfg_ready=0 for that cycle only.
- Same frame with parity=1 -> err_o pulses once, wr_en_o stays 0, bits_o unchanged, wr_count_o unchanged.
- addr=3'b111 (≥ NUM_BLOCKS), data=18'h00000, parity=1 (good parity) -> err_o pulse, no wr_en_o.
- Good frame with cfg_valid toggling every other cycle, plus 3 leading bits with sof=0 -> leading bits dropped without err, same single write result as the first scenario.
- sof=1 on data bit 5 of a frame, followed by a complete good frame addr=3'b000, data=18'h3FFFF, parity=0 -> one err_o pulse at the restart, then wr_en_o=6'b000001, bits_o=18'h3FFFF.
- rst asserted asynchronously during DATA, released, then a good frame sent -> outputs zero immediately on rst, no spurious write, and the new frame writes correctly with wr_count_o=1.

Source files
------------

// File: rtl/sblock_cfg_loader.sv
// sblock_cfg_loader
// Serial configuration front-end for the switch-block array. Frames an
// MSB-first bitstream into {address, 18-bit dot word, even parity}, drops bad
// frames with a one-cycle err_o pulse, and writes good words to exactly one
// switch block through a one-hot, single-cycle write enable.

module sblock_cfg_loader #(
  parameter int NUM_BLOCKS = 6,
  parameter int ADDR_W     = 3,
  parameter int WORD_W     = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_bit,
  input  logic                  cfg_sof,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic [WORD_W-1:0]     bits_o,
  output logic [NUM_BLOCKS-1:0] wr_en_o,
  output logic                  err_o,
  output logic [7:0]            wr_count_o
);

  // The bit counter must reach the longer of the two shifted fields.
  localparam int MAX_LEN = (ADDR_W > WORD_W) ? ADDR_W : WORD_W;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, PAR, WRITE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [WORD_W-1:0]  data_q;
  logic               par_q;

  logic               accept;
  logic               start_frame;
  logic               frame_ok;
  logic [CNT_W-1:0]   cnt_inc;
  logic [ADDR_W-1:0]  addr_shift;
  logic [WORD_W-1:0]  data_shift;

  // A bit only counts when the loader is ready; a start marker outside WRITE
  // always opens a new frame, aborting whatever was in progress.
  assign accept      = cfg_valid && cfg_ready;
  assign start_frame = accept && cfg_sof;
  assign cnt_inc     = bit_cnt + CNT_W'(1);
  assign addr_shift  = (addr_q << 1) | ADDR_W'(cfg_bit);
  assign data_shift  = (data_q << 1) | WORD_W'(cfg_bit);

  // The parity bit closes the frame: the running XOR with it must be zero and
  // the address must name a block that actually exists.
  assign frame_ok = ((par_q ^ cfg_bit) == 1'b0) && (int'(addr_q) < NUM_BLOCKS);

  // Framing FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      par_q      <= 1'b0;
      bits_o     <= '0;
      wr_en_o    <= '0;
      err_o      <= 1'b0;
      wr_count_o <= '0;
      cfg_ready  <= 1'b1;
    end else begin
      wr_en_o <= '0;
      err_o   <= 1'b0;

      if (state == WRITE) begin
        state     <= IDLE;
        cfg_ready <= 1'b1;
      end else if (start_frame) begin
        err_o  <= (state != IDLE);
        addr_q <= ADDR_W'(cfg_bit);
        par_q  <= cfg_bit;
        if (ADDR_W == 1) begin
          state   <= DATA;
          bit_cnt <= '0;
        end else begin
          state   <= ADDR;
          bit_cnt <= CNT_W'(1);
        end
      end else if (accept) begin
        case (state)
          ADDR: begin
            addr_q <= addr_shift;
            par_q  <= par_q ^ cfg_bit;
            if (cnt_inc == CNT_W'(ADDR_W)) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= cnt_inc;
            end
          end
          DATA: begin
            data_q <= data_shift;
            par_q  <= par_q ^ cfg_bit;
            if (cnt_inc == CNT_W'(WORD_W)) begin
              state   <= PAR;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= cnt_inc;
            end
          end
          PAR: begin
            if (frame_ok) begin
              bits_o    <= data_q;
              wr_en_o   <= NUM_BLOCKS'(1) << addr_q;
              state     <= WRITE;
              cfg_ready <= 1'b0;
              if (wr_count_o != 8'hFF) begin
                wr_count_o <= wr_count_o + 8'd1;
              end
            end else begin
              err_o <= 1'b1;
              state <= IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sblock_cfg_loader.sv
// Testbench for sblock_cfg_loader: directed scenarios with fixed expectations
// plus randomized frames checked against a frame-level reference model.

module tb_sblock_cfg_loader;

  localparam int FRAME_LEN = 22;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_bit;
  logic        cfg_sof;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [17:0] bits_o;
  logic [5:0]  wr_en_o;
  logic        err_o;
  logic [7:0]  wr_count_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: bits of the frame being collected, plus what the
  // outputs should look like in the cycle after the latest clock edge.
  bit          m_q[$];
  bit          m_in;
  bit          m_busy;
  logic [5:0]  exp_wr;
  logic        exp_err;
  logic [17:0] exp_bits;
  int          exp_cnt;

  typedef struct {bit v; bit b; bit s;} step_t;

  sblock_cfg_loader #(.NUM_BLOCKS(6), .ADDR_W(3), .WORD_W(18)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_bit    (cfg_bit),
    .cfg_sof    (cfg_sof),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .bits_o     (bits_o),
    .wr_en_o    (wr_en_o),
    .err_o      (err_o),
    .wr_count_o (wr_count_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_in     = 0;
    m_busy   = 0;
    exp_wr   = '0;
    exp_err  = 1'b0;
    exp_bits = '0;
    exp_cnt  = 0;
  endtask

  // One accepted-or-ignored bit at the frame level.
  task automatic model_step(input bit b, input bit s);
    int par, a, d;
    exp_wr  = '0;
    exp_err = 1'b0;
    if (m_busy) begin
      m_busy = 0;
    end else begin
      if (s) begin
        if (m_in) exp_err = 1'b1;
        m_q.delete();
        m_q.push_back(b);
        m_in = 1;
      end else if (m_in) begin
        m_q.push_back(b);
      end
      if (m_in && m_q.size() == FRAME_LEN) begin
        par = 0; a = 0; d = 0;
        for (int i = 0; i < FRAME_LEN; i++) par = par ^ int'(m_q[i]);
        for (int i = 0; i < 3; i++) a = a * 2 + int'(m_q[i]);
        for (int i = 3; i < 21; i++) d = d * 2 + int'(m_q[i]);
        if (par == 0 && a < 6) begin
          exp_wr   = 6'(1 << a);
          exp_bits = 18'(d);
          if (exp_cnt < 255) exp_cnt++;
          m_busy = 1;
        end else begin
          exp_err = 1'b1;
        end
        m_in = 0;
        m_q.delete();
      end
    end
  endtask

  task automatic model_gap();
    exp_wr  = '0;
    exp_err = 1'b0;
    m_busy  = 0;
  endtask

  // Offer one bit for a single cycle, then sit 1 time unit past the edge.
  task automatic drive_bit(input bit b, input bit s);
    cfg_bit   = b;
    cfg_sof   = s;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_sof   = 1'b0;
    model_step(b, s);
  endtask

  task automatic drive_gap(input int n);
    cfg_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      model_gap();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; cfg_sof = 1'b0; cfg_bit = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bits_o !== 18'h0) $display("[TB] FAIL reset_bits: got %h expected %h", bits_o, 18'h0); else n_pass++;
    n_checks++; if (wr_en_o !== 6'b0) $display("[TB] FAIL reset_wr_en: got %b expected %b", wr_en_o, 6'b0); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("[TB] FAIL reset_err: got %b expected 0", err_o); else n_pass++;
    n_checks++; if (wr_count_o !== 8'd0) $display("[TB] FAIL reset_count: got %0d expected 0", wr_count_o); else n_pass++;
    rst = 1'b0;
    drive_gap(2);
    n_checks++; if (cfg_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", cfg_ready); else n_pass++;
    n_checks++; if (wr_en_o !== 6'b0) $display("[TB] FAIL reset_exit_wr_en: got %b expected %b", wr_en_o, 6'b0); else n_pass++;
  endtask

  task automatic test_good_frame();
    logic [21:0] f;
    f = {3'b010, 18'h2A5C3, 1'b0};
    for (int i = 21; i >= 0; i--) begin
      drive_bit(f[i], i == 21);
      if (i > 0) begin
        n_checks++; if (wr_en_o !== 6'b0 || err_o !== 1'b0) $display("[TB] FAIL good_midframe: got wr_en %b err %b expected 000000 0", wr_en_o, err_o); else n_pass++;
      end
    end
    n_checks++; if (wr_en_o !== 6'b000100) $display("[TB] FAIL good_wr_en: got %b expected %b", wr_en_o, 6'b000100); else n_pass++;
    n_checks++; if (bits_o !== 18'h2A5C3) $display("[TB] FAIL good_bits: got %h expected %h", bits_o, 18'h2A5C3); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("[TB] FAIL good_err: got %b expected 0", err_o); else n_pass++;
    n_checks++; if (wr_count_o !== 8'd1) $display("[TB] FAIL good_count: got %0d expected 1", wr_count_o); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b0) $display("[TB] FAIL good_ready_write: got %b expected 0", cfg_ready); else n_pass++;
    drive_gap(1);
    n_checks++; if (wr_en_o !== 6'b0) $display("[TB] FAIL good_wr_en_one_cycle: got %b expected %b", wr_en_o, 6'b0); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1) $display("[TB] FAIL good_ready_after: got %b expected 1", cfg_ready); else n_pass++;
    n_checks++; if (bits_o !== 18'h2A5C3) $display("[TB] FAIL good_bits_hold: got %h expected %h", bits_o, 18'h2A5C3); else n_pass++;
  endtask

  task automatic test_bad_parity();
    logic [21:0] f;
    f = {3'b010, 18'h2A5C3, 1'b1};
    for (int i = 21; i >= 0; i--) drive_bit(f[i], i == 21);
    n_checks++; if (err_o !== 1'b1) $display("[TB] FAIL badpar_err: got %b expected 1", err_o); else n_pass++;
    n_checks++; if (wr_en_o !== 6'b0) $display("[TB] FAIL badpar_wr_en: got %b expected %b", wr_en_o, 6'b0); else n_pass++;
    n_checks++; if (bits_o !== 18'h2A5C3) $display("[TB] FAIL badpar_bits: got %h expected %h", bits_o, 18'h2A5C3); else n_pass++;
    n_checks++; if (wr_count_o !== 8'd1) $display("[TB] FAIL badpar_count: got %0d expected 1", wr_count_o); else n_pass++;
    n_checks++; if (cfg_ready !== 1'b1) $display("[TB] FAIL badpar_ready: got %b expected 1", cfg_ready); else n_pass++;
    drive_gap(1);
    n_checks++; if (err_o !== 1'b0) $display("[TB] FAIL badpar_err_pulse: got %b expected 0", err_o); else n_pass++;
  endtask

  task automatic test_bad_addr();
    logic [21:0] f;
    f = {3'b111, 18'h00000, 1'b1};
    for (int i = 21; i >= 0; i--) drive_bit(f[i], i == 21);
    n_checks++; if (err_o !== 1'b1) $display("[TB] FAIL badaddr_err: got %b expected 1", err_o); else n_pass++;
    n_checks++; if (wr_en_o !== 6'b0) $display("[TB] FAIL badaddr_wr_en: got %b expected %b", wr_en_o, 6'b0); else n_pass++;
    n_checks++; if (bits_o !== 18'h2A5C3) $display("[TB] FAIL badaddr_bits: got %h expected %h", bits_o, 18'h2A5C3); else n_pass++;
    drive_gap(1);
  endtask

  task automatic test_gappy_frame();
    logic [21:0] f;
    f = {3'b010, 18'h2A5C3, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive_bit(1'b1, 1'b0);
      n_checks++; if (err_o !== 1'b0) $display("[TB] FAIL gappy_lead_err: got %b expected 0", err_o); else n_pass++;
      drive_gap(1);
    end
    for (int i = 21; i >= 0; i--) begin
      drive_bit(f[i], i == 21);
      if (i > 0) drive_gap(1);
    end
    n_checks++; if (wr_en_o !== 6'b000100) $display("[TB] FAIL gappy_wr_en: got %b expected %b", wr_en_o, 6'b000100); else n_pass++;
    n_checks++; if (bits_o !== 18'h2A5C3) $display("[TB] FAIL gappy_bits: got %h expected %h", bits_o, 18'h2A5C3); else n_pass++;
    n_checks++; if (wr_count_o !== 8'd2) $display("[TB] FAIL gappy_count: got %0d expected 2", wr_count_o); else n_pass++;
    drive_gap(1);
  endtask

  task automatic test_restart();
    logic [21:0] f;
    logic [21:0] g;
    f = {3'b101, 18'h1234A, 1'b0};
    g = {3'b000, 18'h3FFFF, 1'b0};
    // address bits plus data bits 0..4 of the aborted frame
    for (int i = 21; i >= 14; i--) drive_bit(f[i], i == 21);
    drive_bit(g[21], 1'b1);
    n_checks++; if (err_o !== 1'b1) $display("[TB] FAIL restart_err: got %b expected 1", err_o); else n_pass++;
    n_checks++; if (wr_en_o !== 6'b0) $display("[TB] FAIL restart_wr_en: got %b expected %b", wr_en_o, 6'b0); else n_pass++;
    for (int i = 20; i >= 0; i--) begin
      drive_bit(g[i], 1'b0);
      if (i > 0) begin
        n_checks++; if (err_o !== 1'b0) $display("[TB] FAIL restart_extra_err: got %b expected 0", err_o); else n_pass++;
      end
    end
    n_checks++; if (wr_en_o !== 6'b000001) $display("[TB] FAIL restart_new_wr_en: got %b expected %b", wr_en_o, 6'b000001); else n_pass++;
    n_checks++; if (bits_o !== 18'h3FFFF) $display("[TB] FAIL restart_new_bits: got %h expected %h", bits_o, 18'h3FFFF); else n_pass++;
    n_checks++; if (err_o !== 1'b0) $display("[TB] FAIL restart_new_err: got %b expected 0", err_o); else n_pass++;
    n_checks++; if (wr_count_o !== 8'd3) $display("[TB] FAIL restart_count: got %0d expected 3", wr_count_o); else n_pass++;
    drive_gap(1);
  endtask

  task automatic test_reset_mid_frame();
    logic [21:0] f;
    f = {3'b010, 18'h2A5C3, 1'b0};
    for (int i = 21; i >= 10; i--) drive_bit(f[i], i == 21);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bits_o !== 18'h0) $display("[TB] FAIL rstmid_bits: got %h expected %h", bits_o, 18'h0); else n_pass++;
    n_checks++; if (wr_count_o !== 8'd0) $display("[TB] FAIL rstmid_count: got %0d expected 0", wr_count_o); else n_pass++;
    n_checks++; if (wr_en_o !== 6'b0) $display("[TB] FAIL rstmid_wr_en: got %b expected %b", wr_en_o, 6'b0); else n_pass++;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_gap(1);
      n_checks++; if (wr_en_o !== 6'b0 || err_o !== 1'b0) $display("[TB] FAIL rstmid_spurious: got wr_en %b err %b expected 000000 0", wr_en_o, err_o); else n_pass++;
    end
    for (int i = 21; i >= 0; i--) drive_bit(f[i], i == 21);
    n_checks++; if (wr_en_o !== 6'b000100) $display("[TB] FAIL rstmid_wr_en_after: got %b expected %b", wr_en_o, 6'b000100); else n_pass++;
    n_checks++; if (bits_o !== 18'h2A5C3) $display("[TB] FAIL rstmid_bits_after: got %h expected %h", bits_o, 18'h2A5C3); else n_pass++;
    n_checks++; if (wr_count_o !== 8'd1) $display("[TB] FAIL rstmid_count_after: got %0d expected 1", wr_count_o); else n_pass++;
    drive_gap(1);
  endtask

  task automatic test_random();
    step_t       steps[$];
    step_t       st;
    logic [2:0]  a;
    logic [17:0] d;
    logic [21:0] f;
    int          k;
    for (int fr = 0; fr < 40; fr++) begin
      steps.delete();
      a = 3'($urandom_range(0, 7));
      d = 18'($urandom);
      f = {a, d, (^{a, d}) ^ ($urandom_range(0, 3) == 0)};
      k = $urandom_range(0, 2);
      for (int i = 0; i < k; i++) steps.push_back('{1'b1, 1'($urandom), 1'b0});
      if ($urandom_range(0, 4) == 0) begin
        k = $urandom_range(1, 20);
        for (int i = 0; i < k; i++) steps.push_back('{1'b1, 1'($urandom), i == 0});
      end
      for (int i = 21; i >= 0; i--) begin
        steps.push_back('{1'b1, f[i], i == 21});
        if ($urandom_range(0, 2) == 0) steps.push_back('{1'b0, 1'b0, 1'b0});
      end
      steps.push_back('{1'b1, 1'($urandom), 1'($urandom)});
      steps.push_back('{1'b0, 1'b0, 1'b0});
      foreach (steps[j]) begin
        st = steps[j];
        if (st.v) drive_bit(st.b, st.s);
        else drive_gap(1);
        n_checks++; if (wr_en_o !== exp_wr) $display("[TB] FAIL rand_wr_en: got %b expected %b", wr_en_o, exp_wr); else n_pass++;
        n_checks++; if (err_o !== exp_err) $display("[TB] FAIL rand_err: got %b expected %b", err_o, exp_err); else n_pass++;
        n_checks++; if (bits_o !== exp_bits) $display("[TB] FAIL rand_bits: got %h expected %h", bits_o, exp_bits); else n_pass++;
        n_checks++; if (wr_count_o !== 8'(exp_cnt)) $display("[TB] FAIL rand_count: got %0d expected %0d", wr_count_o, exp_cnt); else n_pass++;
        n_checks++; if (cfg_ready !== !m_busy) $display("[TB] FAIL rand_ready: got %b expected %b", cfg_ready, !m_busy); else n_pass++;
      end
    end
  endtask

  task automatic test_saturation();
    logic [21:0] f;
    logic [2:0]  a;
    logic [17:0] d;
    int          extra;
    extra = 0;
    for (int n = 0; n < 300 && extra < 3; n++) begin
      if (exp_cnt == 255) extra++;
      a = 3'($urandom_range(0, 5));
      d = 18'($urandom);
      f = {a, d, ^{a, d}};
      for (int i = 21; i >= 0; i--) drive_bit(f[i], i == 21);
      if (extra == 3) begin
        n_checks++; if (wr_en_o !== exp_wr) $display("[TB] FAIL sat_wr_en: got %b expected %b", wr_en_o, exp_wr); else n_pass++;
      end
      drive_gap(1);
    end
    n_checks++; if (wr_count_o !== 8'd255) $display("[TB] FAIL sat_count: got %0d expected 255", wr_count_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_parity();
    test_bad_addr();
    test_gappy_frame();
    test_restart();
    test_reset_mid_frame();
    test_random();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
